// File: rtl/friscv_axi_dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : friscv_axi_dmem_responder_if
// Brief    : AXI4 AW/W/B/AR/R bundle between the data-memory initiator and
//            its RAM responder.
// Revision : 1.0
// ============================================================================
interface friscv_axi_dmem_responder_if #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 8,
    parameter int AXI_DATA_W = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [2:0]              awprot;
    logic [3:0]              awcache;
    logic [AXI_ID_W-1:0]     awid;
    logic                    wvalid;
    logic                    wready;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     bid;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [2:0]              arprot;
    logic [3:0]              arcache;
    logic [AXI_ID_W-1:0]     arid;
    logic                    rvalid;
    logic                    rready;
    logic [AXI_ID_W-1:0]     rid;
    logic [1:0]              rresp;
    logic [AXI_DATA_W-1:0]   rdata;

    modport master (
        output awvalid, awaddr, awprot, awcache, awid,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot, arcache, arid,
        output rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rresp, rdata
    );

    modport slave (
        input  awvalid, awaddr, awprot, awcache, awid,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot, arcache, arid,
        input  rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rresp, rdata
    );
endinterface
`default_nettype wire

// File: rtl/friscv_axi_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : friscv_axi_dmem_responder
// Brief    : AXI4 slave serving loads/stores from an internal word RAM with
//            in-order, ID-echoing B and R responses.
// Revision : 1.0
// ============================================================================
module friscv_axi_dmem_responder #(
    parameter int          AXI_ADDR_W = 32,
    parameter int          AXI_ID_W   = 8,
    parameter int          AXI_DATA_W = 32,
    parameter int unsigned MEM_BASE   = 0,
    parameter int          MEM_DEPTH  = 1024,
    parameter int          OSTD_NUM   = 4
) (
    input  wire                         aclk,
    input  wire                         aresetn,
    input  wire                         srst,
    friscv_axi_dmem_responder_if.slave  axi
);
    localparam int c_strb_w = AXI_DATA_W / 8;
    localparam int c_off_w  = $clog2(c_strb_w);
    localparam int c_idx_w  = $clog2(MEM_DEPTH);
    localparam int c_ptr_w  = $clog2(OSTD_NUM);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam logic [AXI_ADDR_W:0] c_base = (AXI_ADDR_W+1)'(MEM_BASE);
    localparam logic [AXI_ADDR_W:0] c_size = (AXI_ADDR_W+1)'(MEM_DEPTH * c_strb_w);
    localparam logic [c_cnt_w-1:0]  c_full = c_cnt_w'(OSTD_NUM);
    localparam logic [1:0]          c_okay   = 2'b00;
    localparam logic [1:0]          c_decerr = 2'b11;

    // Below-base addresses wrap to a huge offset, so one compare covers both bounds.
    function automatic logic in_window(input logic [AXI_ADDR_W-1:0] addr);
        logic [AXI_ADDR_W:0] off;
        off = {1'b0, addr} - c_base;
        return off < c_size;
    endfunction

    logic [AXI_DATA_W-1:0] r_ram [MEM_DEPTH];

    logic                  r_aw_full, r_w_full;
    logic [AXI_ADDR_W-1:0] r_aw_addr;
    logic [AXI_ID_W-1:0]   r_aw_id;
    logic [AXI_DATA_W-1:0] r_w_data;
    logic [c_strb_w-1:0]   r_w_strb;

    logic [AXI_ID_W-1:0]   r_b_id   [OSTD_NUM];
    logic [1:0]            r_b_resp [OSTD_NUM];
    logic [c_ptr_w-1:0]    r_b_wr, r_b_rd;
    logic [c_cnt_w-1:0]    r_b_cnt;

    logic [AXI_ID_W-1:0]   r_r_id   [OSTD_NUM];
    logic [1:0]            r_r_resp [OSTD_NUM];
    logic [AXI_DATA_W-1:0] r_r_data [OSTD_NUM];
    logic [c_ptr_w-1:0]    r_r_wr, r_r_rd;
    logic [c_cnt_w-1:0]    r_r_cnt;

    logic w_live;
    logic w_aw_hs, w_w_hs, w_ar_hs;
    logic w_aw_have, w_w_have, w_commit;
    logic w_bvalid, w_rvalid, w_b_pop, w_r_pop;
    logic [AXI_ADDR_W-1:0] w_cur_awaddr;
    logic [AXI_ID_W-1:0]   w_cur_awid;
    logic [AXI_DATA_W-1:0] w_cur_wdata;
    logic [c_strb_w-1:0]   w_cur_wstrb;
    logic                  w_aw_hit, w_ar_hit;
    logic [c_idx_w-1:0]    w_aw_idx, w_ar_idx;
    logic                  w_unused;

    assign w_unused = ^{axi.awprot, axi.awcache, axi.arprot, axi.arcache};

    assign w_live      = aresetn & ~srst;
    assign axi.awready = w_live & ~r_aw_full;
    assign axi.wready  = w_live & ~r_w_full;
    assign axi.arready = w_live & (r_r_cnt < c_full);

    assign w_aw_hs = axi.awvalid & axi.awready;
    assign w_w_hs  = axi.wvalid  & axi.wready;
    assign w_ar_hs = axi.arvalid & axi.arready;

    // A beat arriving this cycle can commit straight away, bypassing its holding register.
    assign w_aw_have    = r_aw_full | w_aw_hs;
    assign w_w_have     = r_w_full  | w_w_hs;
    assign w_cur_awaddr = r_aw_full ? r_aw_addr : axi.awaddr;
    assign w_cur_awid   = r_aw_full ? r_aw_id   : axi.awid;
    assign w_cur_wdata  = r_w_full  ? r_w_data  : axi.wdata;
    assign w_cur_wstrb  = r_w_full  ? r_w_strb  : axi.wstrb;

    assign w_bvalid = w_live & (r_b_cnt != '0);
    assign w_rvalid = w_live & (r_r_cnt != '0);
    assign w_b_pop  = w_bvalid & axi.bready;
    assign w_r_pop  = w_rvalid & axi.rready;
    assign w_commit = w_live & w_aw_have & w_w_have & ((r_b_cnt != c_full) | w_b_pop);

    assign w_aw_hit = in_window(w_cur_awaddr);
    assign w_ar_hit = in_window(axi.araddr);
    assign w_aw_idx = w_cur_awaddr[c_off_w +: c_idx_w];
    assign w_ar_idx = axi.araddr[c_off_w +: c_idx_w];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_aw_id   <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
        end else if (srst) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_aw_full <= 1'b0;
            end else if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= axi.awaddr;
                r_aw_id   <= axi.awid;
            end
            if (w_commit) begin
                r_w_full <= 1'b0;
            end else if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= axi.wdata;
                r_w_strb <= axi.wstrb;
            end
        end
    end

    // Out-of-window writes are acknowledged with DECERR but never touch the RAM.
    always_ff @(posedge aclk) begin
        if (w_commit && w_aw_hit) begin
            for (int i = 0; i < c_strb_w; i++) begin
                if (w_cur_wstrb[i]) begin
                    r_ram[w_aw_idx][8*i +: 8] <= w_cur_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_commit) begin
            r_b_id[r_b_wr]   <= w_cur_awid;
            r_b_resp[r_b_wr] <= w_aw_hit ? c_okay : c_decerr;
        end
        if (w_ar_hs) begin
            r_r_id[r_r_wr]   <= axi.arid;
            r_r_resp[r_r_wr] <= w_ar_hit ? c_okay : c_decerr;
            r_r_data[r_r_wr] <= w_ar_hit ? r_ram[w_ar_idx] : '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_b_wr  <= '0;
            r_b_rd  <= '0;
            r_b_cnt <= '0;
            r_r_wr  <= '0;
            r_r_rd  <= '0;
            r_r_cnt <= '0;
        end else if (srst) begin
            r_b_wr  <= '0;
            r_b_rd  <= '0;
            r_b_cnt <= '0;
            r_r_wr  <= '0;
            r_r_rd  <= '0;
            r_r_cnt <= '0;
        end else begin
            if (w_commit) r_b_wr <= r_b_wr + c_ptr_w'(1);
            if (w_b_pop)  r_b_rd <= r_b_rd + c_ptr_w'(1);
            if (w_ar_hs)  r_r_wr <= r_r_wr + c_ptr_w'(1);
            if (w_r_pop)  r_r_rd <= r_r_rd + c_ptr_w'(1);
            case ({w_commit, w_b_pop})
                2'b10:   r_b_cnt <= r_b_cnt + c_cnt_w'(1);
                2'b01:   r_b_cnt <= r_b_cnt - c_cnt_w'(1);
                default: r_b_cnt <= r_b_cnt;
            endcase
            case ({w_ar_hs, w_r_pop})
                2'b10:   r_r_cnt <= r_r_cnt + c_cnt_w'(1);
                2'b01:   r_r_cnt <= r_r_cnt - c_cnt_w'(1);
                default: r_r_cnt <= r_r_cnt;
            endcase
        end
    end

    assign axi.bvalid = w_bvalid;
    assign axi.bid    = w_bvalid ? r_b_id[r_b_rd]   : '0;
    assign axi.bresp  = w_bvalid ? r_b_resp[r_b_rd] : '0;
    assign axi.rvalid = w_rvalid;
    assign axi.rid    = w_rvalid ? r_r_id[r_r_rd]   : '0;
    assign axi.rresp  = w_rvalid ? r_r_resp[r_r_rd] : '0;
    assign axi.rdata  = w_rvalid ? r_r_data[r_r_rd] : '0;

endmodule
`default_nettype wire

// File: tb/tb_friscv_axi_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_friscv_axi_dmem_responder
// Brief    : Randomized and directed bench with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_friscv_axi_dmem_responder;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;
    localparam int          OSTD  = 4;

    typedef struct packed { logic [31:0] addr; logic [7:0] id; } aw_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;
    typedef struct packed { logic [7:0] id; logic [1:0] resp; } b_t;
    typedef struct packed { logic [7:0] id; logic [1:0] resp; logic [31:0] data; } r_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic srst = 1'b0;
    always #5 aclk = ~aclk;

    friscv_axi_dmem_responder_if #(.AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_DATA_W(32)) axi ();

    friscv_axi_dmem_responder #(
        .AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_DATA_W(32),
        .MEM_BASE(BASE), .MEM_DEPTH(DEPTH), .OSTD_NUM(OSTD)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .axi(axi)
    );

    int n_cmp = 0;
    int n_bad = 0;
    aw_t awq[$];
    w_t  wq[$];
    b_t  bq[$];
    r_t  rq[$];
    logic [31:0] mem [DEPTH];
    int b_seen = 0;
    int r_seen = 0;
    logic [7:0]  last_bid, last_rid;
    logic [1:0]  last_bresp, last_rresp;
    logic [31:0] last_rdata;
    logic [7:0]  bid_log[$];
    logic [7:0]  rid_log[$];
    int bmode = 1;
    int rmode = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + DEPTH * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Ready generators: 0 = low, 1 = high, 2 = random, 3 = toggle
    initial begin
        axi.bready = 1'b0;
        axi.rready = 1'b0;
        forever begin
            @(negedge aclk);
            case (bmode)
                0: axi.bready = 1'b0;
                1: axi.bready = 1'b1;
                2: axi.bready = 1'($urandom % 2);
                default: axi.bready = ~axi.bready;
            endcase
            case (rmode)
                0: axi.rready = 1'b0;
                1: axi.rready = 1'b1;
                2: axi.rready = 1'($urandom % 2);
                default: axi.rready = ~axi.rready;
            endcase
        end
    end

    // Reference model and per-cycle comparison; all inputs change on negedge only.
    initial begin
        bit live, bpop, rpop;
        r_t nr;
        aw_t a;
        w_t  w;
        forever begin
            @(negedge aclk);
            #2;
            live = aresetn && !srst;
            if (!live) begin
                chk("readies_in_reset", {axi.awready, axi.wready, axi.arready}, 0);
                chk("valids_in_reset", {axi.bvalid, axi.rvalid}, 0);
                chk("b_fields_in_reset", {axi.bid, axi.bresp}, 0);
                chk("r_fields_in_reset", {axi.rid, axi.rresp, axi.rdata}, 0);
                awq.delete(); wq.delete(); bq.delete(); rq.delete();
            end else begin
                chk("awready", axi.awready, awq.size() == 0);
                chk("wready", axi.wready, wq.size() == 0);
                chk("arready", axi.arready, rq.size() < OSTD);
                chk("bvalid", axi.bvalid, bq.size() != 0);
                if (bq.size() != 0) chk("bid_bresp", {axi.bid, axi.bresp}, bq[0]);
                chk("rvalid", axi.rvalid, rq.size() != 0);
                if (rq.size() != 0) chk("rid_rresp_rdata", {axi.rid, axi.rresp, axi.rdata}, rq[0]);

                if (axi.bvalid && axi.bready) begin
                    last_bid = axi.bid; last_bresp = axi.bresp;
                    bid_log.push_back(axi.bid); b_seen++;
                end
                if (axi.rvalid && axi.rready) begin
                    last_rid = axi.rid; last_rresp = axi.rresp; last_rdata = axi.rdata;
                    rid_log.push_back(axi.rid); r_seen++;
                end
                bpop = (bq.size() != 0) && axi.bready;
                rpop = (rq.size() != 0) && axi.rready;
                nr = '0;
                if (axi.arvalid && axi.arready) begin
                    nr.id   = axi.arid;
                    nr.resp = in_win(axi.araddr) ? 2'b00 : 2'b11;
                    nr.data = in_win(axi.araddr) ? mem[widx(axi.araddr)] : 32'h0;
                end
                if (axi.awvalid && axi.awready) awq.push_back('{axi.awaddr, axi.awid});
                if (axi.wvalid && axi.wready) wq.push_back('{axi.wdata, axi.wstrb});
                if (bpop) void'(bq.pop_front());
                if (rpop) void'(rq.pop_front());
                if (axi.arvalid && axi.arready) rq.push_back(nr);
                if (awq.size() != 0 && wq.size() != 0 && bq.size() < OSTD) begin
                    a = awq.pop_front();
                    w = wq.pop_front();
                    if (in_win(a.addr)) begin
                        for (int k = 0; k < 4; k++)
                            if (w.strb[k]) mem[widx(a.addr)][8*k +: 8] = w.data[8*k +: 8];
                    end
                    bq.push_back('{a.id, in_win(a.addr) ? 2'b00 : 2'b11});
                end
            end
        end
    end

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] id);
        int n = 0;
        bit hs = 0;
        @(negedge aclk);
        axi.awvalid = 1'b1; axi.awaddr = addr; axi.awid = id;
        axi.awprot = 3'($urandom); axi.awcache = 4'($urandom);
        while (!hs && n < 300) begin
            #1 hs = axi.awready;
            @(posedge aclk);
            n++;
            if (!hs) @(negedge aclk);
        end
        if (!hs) chk("aw_accept_timeout", 0, 1);
        #1 axi.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        bit hs = 0;
        @(negedge aclk);
        axi.wvalid = 1'b1; axi.wdata = data; axi.wstrb = strb;
        while (!hs && n < 300) begin
            #1 hs = axi.wready;
            @(posedge aclk);
            n++;
            if (!hs) @(negedge aclk);
        end
        if (!hs) chk("w_accept_timeout", 0, 1);
        #1 axi.wvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] id);
        int n = 0;
        bit hs = 0;
        @(negedge aclk);
        axi.arvalid = 1'b1; axi.araddr = addr; axi.arid = id;
        axi.arprot = 3'($urandom); axi.arcache = 4'($urandom);
        while (!hs && n < 300) begin
            #1 hs = axi.arready;
            @(posedge aclk);
            n++;
            if (!hs) @(negedge aclk);
        end
        if (!hs) chk("ar_accept_timeout", 0, 1);
        #1 axi.arvalid = 1'b0;
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [7:0] id);
        fork
            aw_send(addr, id);
            w_send(data, strb);
        join
    endtask

    task automatic wait_b(input int target);
        int n = 0;
        while (b_seen < target && n < 500) begin @(negedge aclk); n++; end
        if (b_seen < target) chk("b_response_timeout", b_seen, target);
    endtask

    task automatic wait_r(input int target);
        int n = 0;
        while (r_seen < target && n < 500) begin @(negedge aclk); n++; end
        if (r_seen < target) chk("r_response_timeout", r_seen, target);
    endtask

    task automatic write_chk(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [7:0] id, input logic [1:0] resp);
        int t = b_seen + 1;
        write(addr, data, strb, id);
        wait_b(t);
        chk("lit_bid", last_bid, id);
        chk("lit_bresp", last_bresp, resp);
    endtask

    task automatic read_chk(input logic [31:0] addr, input logic [7:0] id,
                            input logic [31:0] data, input logic [1:0] resp);
        int t = r_seen + 1;
        ar_send(addr, id);
        wait_r(t);
        chk("lit_rid", last_rid, id);
        chk("lit_rresp", last_rresp, resp);
        chk("lit_rdata", last_rdata, data);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom % 10 == 0) return BASE + 32'd256 + ($urandom % 64) * 4;
        return BASE + ($urandom % 16) * 4 + ($urandom % 4);
    endfunction

    task automatic drain();
        int n = 0;
        bmode = 1; rmode = 1;
        while ((awq.size() + wq.size() + bq.size() + rq.size()) != 0 && n < 1000) begin
            @(negedge aclk); n++;
        end
        chk("drain_empty", awq.size() + wq.size() + bq.size() + rq.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        axi.awvalid = 0; axi.awaddr = 0; axi.awprot = 0; axi.awcache = 0; axi.awid = 0;
        axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0;
        axi.arvalid = 0; axi.araddr = 0; axi.arprot = 0; axi.arcache = 0; axi.arid = 0;
        repeat (3) @(negedge aclk);
        #1 chk("lit_reset_awready", axi.awready, 0);
        chk("lit_reset_bvalid", axi.bvalid, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1 chk("lit_first_cycle_awready", {axi.awready, axi.wready, axi.arready}, 3'b111);

        for (int i = 0; i < DEPTH; i++) write(BASE + i * 4, 32'hA500_0000 | i, 4'hF, 8'(i));
        drain();

        write_chk(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 8'h20, 2'b00);
        read_chk(BASE + 32'h10, 8'h21, 32'hDEADBEEF, 2'b00);

        write_chk(BASE + 32'h20, 32'h11223344, 4'hF, 8'h22, 2'b00);
        write_chk(BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 8'h23, 2'b00);
        read_chk(BASE + 32'h20, 8'h24, 32'h11BB33DD, 2'b00);

        read_chk(BASE + DEPTH * 4, 8'h25, 32'h0, 2'b11);
        write_chk(BASE + DEPTH * 4, 32'h5555_5555, 4'hF, 8'h26, 2'b11);
        read_chk(BASE, 8'h27, 32'hA500_0000, 2'b00);

        // Six writes against a stalled B channel
        drain();
        bmode = 0;
        bid_log.delete();
        t = b_seen;
        fork
            for (int i = 0; i < 6; i++) aw_send(BASE + (20 + i) * 4, 8'h30 + 8'(i));
            for (int i = 0; i < 6; i++) w_send(32'hB000_0000 + i, 4'hF);
            begin
                repeat (14) @(negedge aclk);
                #1;
                chk("lit_full_awready", axi.awready, 0);
                chk("lit_full_wready", axi.wready, 0);
                chk("lit_full_b_entries", bq.size(), 4);
                chk("lit_no_b_while_stalled", b_seen - t, 0);
                bmode = 1;
            end
        join
        wait_b(t + 6);
        for (int i = 0; i < 6; i++)
            chk("lit_bid_order", (i < bid_log.size()) ? bid_log[i] : 8'hxx, 8'h30 + 8'(i));

        // Four back-to-back reads, then a toggling rready
        drain();
        rmode = 0;
        rid_log.delete();
        t = r_seen;
        for (int i = 1; i <= 4; i++) ar_send(BASE + i * 4, 8'(i));
        @(negedge aclk);
        #1 chk("lit_arready_full", axi.arready, 0);
        rmode = 3;
        wait_r(t + 4);
        for (int i = 0; i < 4; i++)
            chk("lit_rid_order", (i < rid_log.size()) ? rid_log[i] : 8'hxx, 8'(i + 1));

        // Synchronous reset with responses pending
        drain();
        rmode = 0; bmode = 0;
        ar_send(BASE, 8'h40);
        ar_send(BASE + 4, 8'h41);
        write(BASE + 48, 32'hCAFE_0001, 4'hF, 8'h42);
        repeat (2) @(negedge aclk);
        srst = 1'b1;
        @(negedge aclk);
        srst = 1'b0;
        #1 chk("lit_srst_valids", {axi.bvalid, axi.rvalid}, 2'b00);
        t = b_seen + r_seen;
        rmode = 1; bmode = 1;
        repeat (10) @(negedge aclk);
        chk("lit_no_stale_after_srst", b_seen + r_seen, t);
        read_chk(BASE + 48, 8'h43, 32'hCAFE_0001, 2'b00);

        // Randomized traffic with independent AW, W and AR timing
        drain();
        bmode = 2; rmode = 2;
        fork
            for (int i = 0; i < 80; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge aclk);
                aw_send(rand_addr(), 8'($urandom));
            end
            for (int i = 0; i < 80; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge aclk);
                w_send($urandom, 4'($urandom));
            end
            for (int i = 0; i < 80; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge aclk);
                ar_send(rand_addr(), 8'($urandom));
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/friscv_axi_dmem_responder.md
Name: friscv_axi_dmem_responder

Overview:
- AXI4 responder that terminates the processing unit's data memory interface (AW/W/B, AR/R); it is the slave end of that initiator.
- Serves loads and stores from an internal word-addressed RAM, returns in-order responses that echo the request IDs, and supports a bounded number of outstanding requests per direction.
- Used as the tightly-coupled data RAM in core testbenches and small SoC configurations with no dCache.

Parameters:
- AXI_ADDR_W, 32, address width
- AXI_ID_W, 8, ID width; echoed unchanged on bid/rid
- AXI_DATA_W, 32, data width; one RAM word per beat (power of two, >=32)
- MEM_BASE, 0, byte base address of the RAM window; aligned to window size
- MEM_DEPTH, 1024, RAM depth in words (power of two)
- OSTD_NUM, 4, max outstanding responses per direction (power of two, >=2)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset, same effect as aresetn
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  AXI_ADDR_W  write byte address
- awprot  in  3  ignored
- awcache  in  4  ignored
- awid  in  AXI_ID_W  write ID
- wvalid/wready  in/out  1  write data handshake
- wdata  in  AXI_DATA_W  write data
- wstrb  in  AXI_DATA_W/8  byte enables
- bvalid/bready  out/in  1  write response handshake
- bid  out  AXI_ID_W  echoed awid
- bresp  out  2  OKAY=2'b00, DECERR=2'b11
- arvalid/arready  in/out  1  read address handshake
- araddr  in  AXI_ADDR_W  read byte address
- arprot  in  3  ignored
- arcache  in  4  ignored
- arid  in  AXI_ID_W  read ID
- rvalid/rready  out/in  1  read data handshake
- rid  out  AXI_ID_W  echoed arid
- rresp  out  2  OKAY/DECERR
- rdata  out  AXI_DATA_W  read data

Behaviour:
- Reset (aresetn low or srst high):
  - bvalid=rvalid=0; bid/rid/bresp/rresp/rdata=0; awready=wready=arready=0 while reset is held.
  - Both FIFOs and both holding registers are flushed; RAM contents are kept.
  - Reset mid-transaction drops all pending responses silently.
- First cycle after reset: awready=wready=arready=1.
- Address decode:
  - Word index = addr[log2(AXI_DATA_W/8) +: log2(MEM_DEPTH)]; low address bits are ignored.
  - In range when MEM_BASE <= addr < MEM_BASE + MEM_DEPTH*AXI_DATA_W/8; otherwise DECERR.
- Write path:
  - AW and W are independent, each captured in a 1-entry holding register; awready/wready are low while the respective register is full.
  - Commit happens in the cycle both registers are full and the B FIFO (depth OSTD_NUM) is not full.
  - On commit: write bytes where wstrb=1 (in range only; DECERR writes are discarded), push {awid, bresp}, free both registers.
  - AW and W accepted in cycle N → bvalid in cycle N+1 at earliest.
  - AW before W, W before AW and same-cycle arrival must all work.
- B output: bvalid = B FIFO not empty; pop on bvalid&bready; bid/bresp are held stable while bvalid&!bready.
- Read path:
  - arready = (R FIFO count + in-flight read) < OSTD_NUM.
  - AR handshake in cycle N: RAM read in N, {arid, rresp, data} pushed into the R FIFO at N+1, rvalid=1 at N+1 if the FIFO was empty.
  - DECERR reads return rdata=0.
  - Back-to-back ARs are accepted every cycle while there is room.
- R output: pop on rvalid&rready; rid/rresp/rdata are held stable while stalled.
- Same-cycle write commit and AR accept to the same word: the read returns the pre-write data (read-first). A read accepted in any later cycle sees the new data.
- Responses on each channel are strictly in request order. No ordering exists between the B and R channels.
- A full FIFO with simultaneous push and pop is legal; the count is unchanged and there is no bubble.

Test Plan:
- Write awaddr=MEM_BASE+0x10, wdata=32'hDEADBEEF, wstrb=4'hF, awid=8'h20; then read the same address with arid=8'h21 → bresp=0, bid=8'h20; rdata=32'hDEADBEEF, rid=8'h21, rresp=0.
- Write 32'h11223344 (full strobe), then write 32'hAABBCCDD with wstrb=4'b0101, then read back → rdata=32'h11BB33DD.
- Read and write at MEM_BASE+MEM_DEPTH*4 → rresp=2'b11 with rdata=0; bresp=2'b11; a follow-up read at the in-range alias address returns unchanged data.
- Hold bready=0 and issue 6 writes (OSTD_NUM=4) → 4 commits complete; awready and wready stay low on the 6th; releasing bready returns bid in issue order with no loss.
- Issue 4 back-to-back ARs with IDs 1,2,3,4 while rready toggles 1010... → rid sequence 1,2,3,4, each beat stable while stalled, arready drops once 4 are outstanding.
- Assert srst with 2 reads and 1 write outstanding → bvalid=rvalid=0 the next cycle, no stale response after release; RAM still holds previously written data.
